// File: rtl/n_bit_pipe_register.sv
// n_bit_pipe_register
//   DEPTH-stage chain of N-bit registers with a per-stage valid bit and a
//   valid/ready handshake on both ends. Words move forward whenever the next
//   stage is empty or is itself moving, so bubbles collapse even while the
//   output is stalled. Strict FIFO order, no loss, no duplication.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (clears valid, data and count)
//   flush      synchronous clear of all valid bits and count (data retained)
//   in_valid   upstream offers in_data
//   in_data    upstream word, N bits
//   in_ready   block accepts in_data this cycle
//   out_valid  out_data holds a valid word (registered)
//   out_data   word at the last stage (registered)
//   out_ready  downstream accepts out_data
//   count      number of valid stages, 0..DEPTH
module n_bit_pipe_register #(
  parameter  int N     = 6,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [N-1:0]  out_data,
  input  logic          out_ready,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0] r_v;
  logic [N-1:0]     r_d [DEPTH];
  logic [CW-1:0]    r_count;

  logic [DEPTH-1:0] w_go;
  logic [DEPTH-1:0] w_acc;
  logic [DEPTH-1:0] w_src_v;
  logic [N-1:0]     w_src_d [DEPTH];
  logic             w_in_xfer;
  logic             w_out_xfer;

  // Move chain: evaluated from the output end backwards, so a stage may
  // advance into a slot that is being vacated in the same cycle.
  always_comb begin
    w_go    = '0;
    w_acc   = '0;
    w_src_v = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_src_d[i] = '0;
    end

    w_go[DEPTH-1] = r_v[DEPTH-1] & out_ready;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      w_go[DEPTH-1-k] = r_v[DEPTH-1-k] & (~r_v[DEPTH-k] | w_go[DEPTH-k]);
    end

    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_acc[i] = ~r_v[i] | w_go[i];
    end

    // Source of each stage: upstream port for stage 0, previous stage otherwise.
    w_src_v[0] = in_valid;
    w_src_d[0] = in_data;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      w_src_v[i] = w_go[i-1];
      w_src_d[i] = r_d[i-1];
    end
  end

  assign in_ready   = w_acc[0] & ~flush;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = r_v[DEPTH-1] & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v     <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_d[i] <= '0;
      end
    end else if (flush) begin
      // Data registers keep their contents; only occupancy is cleared.
      r_v     <= '0;
      r_count <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (w_acc[i]) begin
          r_v[i] <= w_src_v[i];
          if (w_src_v[i]) begin
            r_d[i] <= w_src_d[i];
          end
        end
      end
      case ({w_in_xfer, w_out_xfer})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_valid = r_v[DEPTH-1];
  assign out_data  = r_d[DEPTH-1];
  assign count     = r_count;

  a_count_matches_valid : assert property (
    @(posedge clk) disable iff (rst) (r_count == CW'($countones(r_v)))
  );

  a_count_bounded : assert property (
    @(posedge clk) disable iff (rst) (int'(r_count) <= DEPTH)
  );

endmodule
